// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : shared UART constants and receiver state encoding
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  localparam int UART_CNT_W  = 14;
  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
//------------------------------------------------------------------------------
// uart_sync2 : two-flop synchroniser with parameterised reset value
// Revision   : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
    end
  end

  assign sync_out = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// uart_rx : 8-N-1 LSB-first serial receiver with mid-bit sampling.
//           Optional even parity bit when UART_RX_PARITY_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Rx_Serial,
  output logic [UART_DATA_W-1:0] Rx_Byte,
  output logic                   Rx_Valid,
  output logic                   Rx_Active,
  output logic                   Rx_Frame_Err,
  output logic                   Rx_Parity_Err
);

  localparam logic [UART_CNT_W-1:0] c_HALF_M1 = UART_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [UART_CNT_W-1:0] c_BIT_M1  = UART_CNT_W'(CLKS_PER_BIT - 1);

  logic                   w_rx_s;
  uart_state_e            r_state,  w_state_nxt;
  logic [UART_CNT_W-1:0]  r_cnt,    w_cnt_nxt;
  logic [2:0]             r_idx,    w_idx_nxt;
  logic [UART_DATA_W-1:0] r_shift,  w_shift_nxt;
  logic [UART_DATA_W-1:0] r_byte,   w_byte_nxt;
  logic                   r_valid,  w_valid_nxt;
  logic                   r_active, w_active_nxt;
  logic                   r_ferr,   w_ferr_nxt;
  logic                   w_par_bad;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_bad, w_par_bad_nxt;
  logic                   r_perr,    w_perr_nxt;
`endif

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk      (Clk),
    .rst      (Rst),
    .async_in (Rx_Serial),
    .sync_out (w_rx_s)
  );

`ifdef UART_RX_PARITY_EN
  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_byte    <= w_byte_nxt;
      r_valid   <= w_valid_nxt;
      r_active  <= w_active_nxt;
      r_ferr    <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
      r_perr    <= w_perr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_shift_nxt   = r_shift;
    w_byte_nxt    = r_byte;
    w_valid_nxt   = 1'b0;
    w_active_nxt  = r_active;
    w_ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_perr_nxt    = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = 1'b0;
`endif
        if (!w_rx_s) begin
          w_state_nxt = START;
        end
      end

      // A line that is high again at mid-start was a glitch.
      START: begin
        if (r_cnt == c_HALF_M1) begin
          w_cnt_nxt = '0;
          if (!w_rx_s) begin
            w_state_nxt  = DATA;
            w_active_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + UART_CNT_W'(1);
        end
      end

      DATA: begin
        if (r_cnt == c_BIT_M1) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rx_s;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + UART_CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt == c_BIT_M1) begin
          w_cnt_nxt     = '0;
          w_par_bad_nxt = w_rx_s ^ (^r_shift);
          w_state_nxt   = STOP;
        end else begin
          w_cnt_nxt = r_cnt + UART_CNT_W'(1);
        end
      end
`endif

      // Leaving at mid-stop lets an immediately following start edge be seen.
      STOP: begin
        if (r_cnt == c_BIT_M1) begin
          w_cnt_nxt    = '0;
          w_active_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
          w_perr_nxt   = r_par_bad;
`endif
          if (w_rx_s) begin
            if (!w_par_bad) begin
              w_byte_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + UART_CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign Rx_Byte      = r_byte;
  assign Rx_Valid     = r_valid;
  assign Rx_Active    = r_active;
  assign Rx_Frame_Err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign Rx_Parity_Err = r_perr;
`else
  assign Rx_Parity_Err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8-N-1 LSB-first, the receive counterpart of `uart_tx` on the same link and baud configuration. Synchronises the `Rx_Serial` line and validates the start bit at mid-bit. Samples each data bit at its centre and presents the byte with a one-cycle `Rx_Valid` strobe. Sits between the board RX pin and the byte-level consumer logic, mirroring `uart_tx`'s `Tx_Done` strobe convention.

## Interface
- `CLKS_PER_BIT`, default 10417: `Clk` cycles per bit, e.g. 100 MHz / 9600 baud. Legal range 4..16383. Counter is 14 bits.
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Rst`  in  1  reset, asynchronous, active-high.
- `Rx_Serial`  in  1  serial line, idle high; asynchronous to `Clk`.
- `Rx_Byte`  out  8  last received byte; holds its value until the next good frame.
- `Rx_Valid`  out  1  one-cycle pulse; `Rx_Byte` is new and good.
- `Rx_Active`  out  1  high from validated start bit until frame end.
- `Rx_Frame_Err`  out  1  one-cycle pulse; stop bit sampled low.
- `Rx_Parity_Err`  out  1  one-cycle pulse; parity mismatch. Constant 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- **Input synchroniser:** two flops, reset to 1. All decisions use the synchronised line `rx_s`.
- `HALF` = floor(`CLKS_PER_BIT`/2). Bit counter `cnt` is 14 bits wide. Bit index is 3 bits.
- **States:** IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- **IDLE:** `cnt`=0, index=0. `rx_s`==0 → START.
- **START:**
  - `cnt` increments.
  - At `cnt`==`HALF`-1, sample `rx_s`.
  - `rx_s`==0 → DATA, `cnt`=0, `Rx_Active`=1.
  - `rx_s`==1 → false start, back to IDLE. No outputs change.
- **DATA:**
  - At `cnt`==`CLKS_PER_BIT`-1, shift `rx_s` into bit[index] and clear `cnt`.
  - After index 7 → PARITY if the macro is defined, else STOP. Index wraps to 0.
- **STOP:** at `cnt`==`CLKS_PER_BIT`-1, sample `rx_s`.
  - 1 with no parity error: load `Rx_Byte`, pulse `Rx_Valid`, go to IDLE.
  - 1 with a parity error: pulse `Rx_Parity_Err`, leave `Rx_Byte` unchanged, go to IDLE.
  - 0: pulse `Rx_Frame_Err`, leave `Rx_Byte` unchanged, go to WAIT_IDLE. A parity error in the same frame is also flagged.
- **`Rx_Active`:** cleared on every exit from STOP.
- **WAIT_IDLE:** stay until `rx_s`==1 (break/line-low condition), then IDLE.
- **Back-to-back frames:** IDLE is re-entered at mid-stop, so a start edge arriving immediately after the stop bit is caught.
- **Strobe exclusivity:** `Rx_Valid`, `Rx_Frame_Err` and `Rx_Parity_Err` are registered and mutually exclusive, except that a frame error may coincide with a parity error.
- **Reset mid-frame:** abandons the frame immediately.
  - Outputs return to their reset values.
  - State returns to IDLE.
  - No strobe is emitted.
- **Reset values:** `Rx_Byte`=8'h00, `Rx_Valid`=0, `Rx_Active`=0, `Rx_Frame_Err`=0, `Rx_Parity_Err`=0. State is IDLE, counters are 0.

## Timing
- Edge 0 is the first `Clk` edge at which the first synchroniser flop captures a 0.
  - Start detect at edge 2.
  - Start validate at edge 2+`HALF`.
  - Data bit k sampled at edge 2+`HALF`+(k+1)·`CLKS_PER_BIT`.
  - Stop bit sampled at edge 2+`HALF`+9·`CLKS_PER_BIT`; add `CLKS_PER_BIT` with parity.
- `Rx_Valid` and the error strobes are high for exactly the one cycle after the stop-sample edge. `Rx_Byte` updates on that same edge.
- `Rx_Active` rises the cycle after edge 2+`HALF` and falls together with the strobe.
- **Glitch rejection:** a low pulse shorter than `HALF` synchronised cycles is rejected as a false start.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
  - **Defined:** one even-parity bit is expected between bit 7 and the stop bit, sampled at mid-bit. A mismatch asserts `Rx_Parity_Err` and suppresses `Rx_Valid`.
  - **Not defined:** no PARITY state, frame is 8-N-1, and `Rx_Parity_Err` is tied 0.

## Structure
- **Package `uart_pkg`:**
  - State enum localparams: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - Counter width constant `UART_CNT_W`=14, shared with `uart_tx`.
  - Data width constant `UART_DATA_W`=8.
- **Sub-module:** `uart_sync2`, a 2-flop synchroniser with parameterised reset value. It is instantiated once here and is reusable elsewhere.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Drive 8'hA5 as 8-N-1 → one `Rx_Valid` pulse with `Rx_Byte`=8'hA5, no error strobes, `Rx_Active` high for the expected window.
- Send 8'h00 then 8'hFF back-to-back with no idle gap → two `Rx_Valid` pulses carrying 8'h00 then 8'hFF.
- Low glitch of 5 cycles on an idle line → no strobes, `Rx_Active` stays 0, state returns to IDLE.
- Frame 8'h3C with the stop bit held low for 3 bit times → `Rx_Frame_Err` pulses once and `Rx_Byte` keeps its prior value. A following 8'h81 frame after the line returns high → `Rx_Valid` with 8'h81.
- Assert `Rst` during data bit 4 of a frame → all outputs go to reset values within the same cycle and no strobe is emitted. The next clean 8'h5A frame → `Rx_Valid` with 8'h5A.
- With `UART_RX_PARITY_EN`: 8'h07 sent with parity 1 → `Rx_Valid`. 8'h07 sent with parity 0 → `Rx_Parity_Err` only, `Rx_Byte` unchanged.
